// File: rtl/avalon_mm_pkg.sv
// Shared definitions for the Avalon-MM pipeline bridge.
// Holds the default-width command record and its width constants.
package avalon_mm_pkg;

    localparam int CMD_ADDR_W = 20;
    localparam int CMD_DATA_W = 16;
    localparam int CMD_BE_W   = CMD_DATA_W / 8;

    // One buffered bus command; is_write selects write vs read.
    typedef struct packed {
        logic [CMD_ADDR_W-1:0] address;
        logic [CMD_BE_W-1:0]   byteenable;
        logic [CMD_DATA_W-1:0] writedata;
        logic                  is_write;
    } cmd_t;

endpackage

// File: rtl/avalon_mm_cmd_fifo.sv
// Two-entry in-order command buffer with registered full/empty flags.
// Ports: clk/rst, push + push_data, pop, full, empty, head (oldest entry).
module avalon_mm_cmd_fifo
    import avalon_mm_pkg::*;
#(
    parameter type T = cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);

    T     mem [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            // Flags only move on push-only or pop-only cycles.
            unique case ({push, pop})
                2'b10: begin
                    full  <= ~empty;
                    empty <= 1'b0;
                end
                2'b01: begin
                    full  <= 1'b0;
                    empty <= ~full;
                end
                default: ;
            endcase
        end
    end

    // Payload needs no reset: empty entries are never presented.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/avalon_mm_pipe_bridge.sv
// Avalon-MM pipeline bridge: buffers slave commands, throttles reads to
// MAX_PENDING outstanding, returns read data one cycle later, flags
// orphan responses on err. Ports: clk, rst, s_* slave side, m_* master.
module avalon_mm_pipe_bridge
    import avalon_mm_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int MAX_PENDING = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   s_address,
    input  logic                s_read,
    input  logic                s_write,
    input  logic [DATA_W/8-1:0] s_byteenable,
    input  logic [DATA_W-1:0]   s_writedata,
    output logic                s_waitrequest,
    output logic [DATA_W-1:0]   s_readdata,
    output logic                s_readdatavalid,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic                m_waitrequest,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_readdatavalid,
    output logic                err
);

    localparam int BE_W   = DATA_W / 8;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);

    // Same layout as cmd_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [BE_W-1:0]   byteenable;
        logic [DATA_W-1:0] writedata;
        logic              is_write;
    } bridge_cmd_t;

    bridge_cmd_t       push_cmd;
    bridge_cmd_t       head;
    logic              full;
    logic              empty;
    logic              accept;
    logic              issue;
    logic              issue_read;
    logic              rsp_ok;
    logic [PEND_W-1:0] pending;

    // Read+write together is taken as a write.
    assign accept   = (s_read | s_write) & ~full;
    assign push_cmd = '{
        address:    s_address,
        byteenable: s_byteenable,
        writedata:  s_writedata,
        is_write:   s_write
    };

    avalon_mm_cmd_fifo #(
        .T(bridge_cmd_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_data(push_cmd),
        .pop      (issue),
        .full     (full),
        .empty    (empty),
        .head     (head)
    );

    assign s_waitrequest = full;

    assign m_address    = head.address;
    assign m_byteenable = head.byteenable;
    assign m_writedata  = head.writedata;
    assign m_write      = ~empty & head.is_write;
    assign m_read       = ~empty & ~head.is_write
                        & (pending < PEND_W'(MAX_PENDING));

    assign issue      = (m_read | m_write) & ~m_waitrequest;
    assign issue_read = m_read & ~m_waitrequest;
    // A response with nothing outstanding is an orphan and is dropped.
    assign rsp_ok     = m_readdatavalid & (pending != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            pending         <= '0;
            err             <= 1'b0;
            s_readdata      <= '0;
            s_readdatavalid <= 1'b0;
        end else begin
            if (issue_read & ~rsp_ok)
                pending <= pending + PEND_W'(1);
            else if (~issue_read & rsp_ok)
                pending <= pending - PEND_W'(1);
            if (m_readdatavalid & ~rsp_ok)
                err <= 1'b1;
            s_readdatavalid <= rsp_ok;
            if (rsp_ok)
                s_readdata <= m_readdata;
        end
    end

endmodule

// File: tb/tb_avalon_mm_pipe_bridge.sv
// Directed bench for avalon_mm_pipe_bridge with command and response
// scoreboards checked every cycle.
module tb_avalon_mm_pipe_bridge;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int BW = 2;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] s_address = '0;
    logic          s_read = 1'b0;
    logic          s_write = 1'b0;
    logic [BW-1:0] s_byteenable = '0;
    logic [DW-1:0] s_writedata = '0;
    logic          s_waitrequest;
    logic [DW-1:0] s_readdata;
    logic          s_readdatavalid;
    logic [AW-1:0] m_address;
    logic          m_read;
    logic          m_write;
    logic [BW-1:0] m_byteenable;
    logic [DW-1:0] m_writedata;
    logic          m_waitrequest = 1'b0;
    logic [DW-1:0] m_readdata = '0;
    logic          m_readdatavalid = 1'b0;
    logic          err;

    avalon_mm_pipe_bridge #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_PENDING(MP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_address      (s_address),
        .s_read         (s_read),
        .s_write        (s_write),
        .s_byteenable   (s_byteenable),
        .s_writedata    (s_writedata),
        .s_waitrequest  (s_waitrequest),
        .s_readdata     (s_readdata),
        .s_readdatavalid(s_readdatavalid),
        .m_address      (m_address),
        .m_read         (m_read),
        .m_write        (m_write),
        .m_byteenable   (m_byteenable),
        .m_writedata    (m_writedata),
        .m_waitrequest  (m_waitrequest),
        .m_readdata     (m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .err            (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] be;
        logic [DW-1:0] d;
        logic          w;
    } exp_t;

    exp_t          cmd_q[$];
    logic [DW-1:0] rsp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            occ = 0;
    int            model_pend = 0;
    logic          model_err = 1'b0;
    int            n_reads = 0;
    int            n_writes = 0;
    int            hold = 0;
    logic          hold_valid = 1'b0;
    exp_t          hold_cmd;
    logic          last_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, update models, return at posedge+1.
    task automatic step();
        exp_t e;
        logic acc;
        logic iss;
        logic rsp;
        @(negedge clk);
        last_acc = 1'b0;
        if (!rst) begin
            if (rsp_q.size() != 0) begin
                chk("rsp_valid", 32'(s_readdatavalid), 32'd1);
                chk("rsp_data", 32'(s_readdata), 32'(rsp_q.pop_front()));
            end else begin
                chk("rsp_idle", 32'(s_readdatavalid), 32'd0);
            end
            chk("swait", 32'(s_waitrequest), 32'(occ == 2));
            chk("err", 32'(err), 32'(model_err));
            if (m_read && m_write) chk("both_strobes", 32'd1, 32'd0);
            if (hold_valid) begin
                chk("stable_strobe", 32'(m_read | m_write), 32'd1);
                chk("stable_kind", 32'(m_write), 32'(hold_cmd.w));
                chk("stable_addr", 32'(m_address), 32'(hold_cmd.a));
                if (hold_cmd.w) begin
                    chk("stable_be", 32'(m_byteenable), 32'(hold_cmd.be));
                    chk("stable_data", 32'(m_writedata), 32'(hold_cmd.d));
                end
            end
            acc = (s_read | s_write) & !s_waitrequest;
            iss = (m_read | m_write) & !m_waitrequest;
            if (iss) begin
                if (m_read) chk("read_gate", 32'(model_pend < MP), 32'd1);
                if (cmd_q.size() == 0) begin
                    chk("spurious_issue", 32'd1, 32'd0);
                end else begin
                    e = cmd_q.pop_front();
                    chk("issue_kind", 32'(m_write), 32'(e.w));
                    chk("issue_addr", 32'(m_address), 32'(e.a));
                    if (e.w) begin
                        chk("issue_be", 32'(m_byteenable), 32'(e.be));
                        chk("issue_data", 32'(m_writedata), 32'(e.d));
                    end
                end
                if (m_write) n_writes++;
                if (m_read) n_reads++;
            end
            hold_valid = (m_read | m_write) & m_waitrequest;
            hold_cmd.a = m_address;
            hold_cmd.be = m_byteenable;
            hold_cmd.d = m_writedata;
            hold_cmd.w = m_write;
            if (acc) begin
                e.a = s_address;
                e.be = s_byteenable;
                e.d = s_writedata;
                e.w = s_write;
                cmd_q.push_back(e);
                last_acc = 1'b1;
            end
            occ = occ + int'(acc) - int'(iss);
            rsp = m_readdatavalid && (model_pend > 0);
            if (m_readdatavalid && model_pend == 0) model_err = 1'b1;
            if (rsp) rsp_q.push_back(m_readdata);
            model_pend = model_pend + int'(iss & m_read) - int'(rsp);
        end else begin
            cmd_q.delete();
            rsp_q.delete();
            occ = 0;
            model_pend = 0;
            model_err = 1'b0;
            hold_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        if (hold > 0) begin
            hold--;
            if (hold == 0) m_waitrequest = 1'b0;
        end
    endtask

    task automatic send(input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be);
        int n;
        n = 0;
        s_read = rd;
        s_write = wr;
        s_address = a;
        s_writedata = d;
        s_byteenable = be;
        do begin
            step();
            n++;
        end while (!last_acc && n < 40);
        if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
        s_read = 1'b0;
        s_write = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_swait"}, 32'(s_waitrequest), 32'd0);
        chk({tag, "_rdv"}, 32'(s_readdatavalid), 32'd0);
        chk({tag, "_rdata"}, 32'(s_readdata), 32'd0);
        chk({tag, "_mread"}, 32'(m_read), 32'd0);
        chk({tag, "_mwrite"}, 32'(m_write), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step();
        step();
        rst = 1'b0;
        reset_checks("rst0");

        // Single write, one-cycle latency
        send(1'b0, 1'b1, 20'h00010, 16'hBEEF, 2'b11);
        chk("t1_mwrite", 32'(m_write), 32'd1);
        chk("t1_addr", 32'(m_address), 32'h00010);
        chk("t1_data", 32'(m_writedata), 32'hBEEF);
        step();
        chk("t1_mwrite_done", 32'(m_write), 32'd0);
        chk("t1_nwrites", 32'(n_writes), 32'd1);

        // Six back-to-back reads, no responses
        for (int i = 0; i < 6; i++)
            send(1'b1, 1'b0, 20'h00100 + 20'(i), 16'h0, 2'b11);
        chk("t2_issued", 32'(n_reads), 32'd4);
        chk("t2_swait", 32'(s_waitrequest), 32'd1);
        chk("t2_mread", 32'(m_read), 32'd0);
        step();
        step();
        chk("t2_still", 32'(n_reads), 32'd4);
        m_readdata = 16'h0A01;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("t2_release", 32'(n_reads), 32'd5);
        chk("t2_swait_free", 32'(s_waitrequest), 32'd0);
        step();
        chk("t2_gate_again", 32'(m_read), 32'd0);
        for (int i = 0; i < 30; i++) begin
            m_readdatavalid = (model_pend > 0);
            m_readdata = 16'hA000 + 16'(i);
            step();
        end
        m_readdatavalid = 1'b0;
        chk("t2_all_reads", 32'(n_reads), 32'd6);
        chk("t2_drained", 32'(cmd_q.size()), 32'd0);

        // Writes under master stall, read+write taken as write
        hold = 5;
        m_waitrequest = 1'b1;
        send(1'b0, 1'b1, 20'h00200, 16'h1111, 2'b01);
        send(1'b1, 1'b1, 20'h00201, 16'h2222, 2'b10);
        chk("t3_swait", 32'(s_waitrequest), 32'd1);
        send(1'b0, 1'b1, 20'h00202, 16'h3333, 2'b11);
        for (int i = 0; i < 4; i++) step();
        chk("t3_nwrites", 32'(n_writes), 32'd4);

        // Response concurrent with a read issue
        send(1'b1, 1'b0, 20'h00300, 16'h0, 2'b11);
        step();
        send(1'b1, 1'b0, 20'h00301, 16'h0, 2'b11);
        chk("t4_mread", 32'(m_read), 32'd1);
        m_readdata = 16'h1234;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        chk("t4_rdv", 32'(s_readdatavalid), 32'd1);
        chk("t4_rdata", 32'(s_readdata), 32'h1234);
        m_readdata = 16'h5678;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("t4_err_clear", 32'(err), 32'd0);

        // Orphan response
        m_readdata = 16'hDEAD;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("t5_no_rdv", 32'(s_readdatavalid), 32'd0);
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_rdata_held", 32'(s_readdata), 32'h5678);
        for (int i = 0; i < 3; i++) step();
        chk("t5_err_sticky", 32'(err), 32'd1);

        // Reset with reads outstanding and buffer full
        send(1'b1, 1'b0, 20'h00400, 16'h0, 2'b11);
        send(1'b1, 1'b0, 20'h00401, 16'h0, 2'b11);
        send(1'b1, 1'b0, 20'h00402, 16'h0, 2'b11);
        step();
        m_waitrequest = 1'b1;
        send(1'b1, 1'b0, 20'h00403, 16'h0, 2'b11);
        send(1'b1, 1'b0, 20'h00404, 16'h0, 2'b11);
        chk("t6_full", 32'(s_waitrequest), 32'd1);
        chk("t6_pend", 32'(model_pend), 32'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        reset_checks("rst1");
        m_waitrequest = 1'b0;
        m_readdata = 16'h0BAD;
        m_readdatavalid = 1'b1;
        step();
        m_readdatavalid = 1'b0;
        step();
        chk("t6_stale_err", 32'(err), 32'd1);
        chk("t6_stale_rdv", 32'(s_readdatavalid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/avalon_mm_pipe_bridge.md
AVALON_MM_PIPE_BRIDGE -- requirements
Module: avalon_mm_pipe_bridge

Interface
REQ-001 Parameter ADDR_W, default 20, word address width.
REQ-002 Parameter DATA_W, default 16, data width; multiple of 8; BE_W = DATA_W/8.
REQ-003 Parameter MAX_PENDING, default 4, maximum outstanding reads on master side; range 1..64.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 s_address  in  ADDR_W  slave command address.
REQ-008 s_read / s_write  in  1 each  slave command strobes.
REQ-009 s_byteenable  in  BE_W  slave byte enables.
REQ-010 s_writedata  in  DATA_W  slave write data.
REQ-011 s_waitrequest  out  1  slave stall, driven directly from a flop.
REQ-012 s_readdata / s_readdatavalid  out  DATA_W / 1  registered read response.
REQ-013 m_address, m_read, m_write, m_byteenable, m_writedata  out  same widths  master command.
REQ-014 m_waitrequest  in  1  master stall.
REQ-015 m_readdata / m_readdatavalid  in  DATA_W / 1  master read response.
REQ-016 err  out  1  sticky flag: response received with no outstanding read.

Function
REQ-017 Commands SHALL pass through a 2-entry in-order command buffer; a slave command is accepted when (s_read|s_write) & !s_waitrequest.
REQ-018 s_waitrequest SHALL be 1 exactly when the buffer holds 2 entries; no combinational path from any m_* input to s_waitrequest.
REQ-019 s_read & s_write both high SHALL be accepted as a write; read strobe ignored.
REQ-020 Buffer head SHALL drive m_*; m_write = head valid & head is write; m_read = head valid & head is read & pending < MAX_PENDING.
REQ-021 Head SHALL pop when (m_read|m_write) & !m_waitrequest; push and pop in the same cycle SHALL leave occupancy unchanged.
REQ-022 Latency: command accepted into empty buffer at edge N SHALL appear on m_* in the cycle following edge N (one-cycle latency).
REQ-023 m_* command fields SHALL remain stable while m_waitrequest is high.
REQ-024 pending counter, width $clog2(MAX_PENDING+1): +1 on issued read, -1 on m_readdatavalid, unchanged when both occur; never exceeds MAX_PENDING or underflows.
REQ-025 m_readdatavalid with pending == 0 SHALL be dropped (no s_readdatavalid) and set err until reset.
REQ-026 s_readdata/s_readdatavalid SHALL equal m_readdata/m_readdatavalid delayed one cycle; s_readdata is held when s_readdatavalid is low.
REQ-027 Responses SHALL be returned in issue order; the bridge does no reordering or buffering of responses (slave never stalls responses).
REQ-028 Writes SHALL not be gated by pending; a write behind a stalled read waits in order.

Reset
REQ-029 rst SHALL empty the buffer, clear pending and err, and force s_waitrequest=0, s_readdatavalid=0, m_read=0, m_write=0, s_readdata=0.
REQ-030 Reads outstanding at reset SHALL be forgotten; their later responses fall under REQ-025.
REQ-031 Command fields of empty buffer entries (address, data, byteenable) are don't-care after reset.

Structure
REQ-032 Shared package avalon_mm_pkg SHALL hold the command struct typedef (address, byteenable, writedata, is_write), parametrised via package-level width constants or type parameters.
REQ-033 The 2-entry buffer SHALL be a sub-module avalon_mm_cmd_fifo with push/pop/full/empty and head output.
REQ-034 Target implementation: 150-300 lines of RTL total.

Verification
REQ-035 Single write 0x00010, data 0xBEEF, be 2'b11, m_waitrequest=0 -> m_write high 1 cycle after acceptance with same fields; s_waitrequest never set.
REQ-036 MAX_PENDING=4, 6 back-to-back reads, no responses -> exactly 4 issued, m_read low, s_waitrequest=1 after 2 more accepted; one response releases 1 read.
REQ-037 m_waitrequest held high 5 cycles with 3 slave writes -> s_waitrequest=1 after 2 accepted, m_* fields stable, all 3 writes issued in order once released.
REQ-038 Read response 0x1234 on m_readdatavalid at cycle k, with simultaneous read issue -> s_readdata=0x1234 valid at k+1; pending unchanged.
REQ-039 m_readdatavalid with pending=0 -> no s_readdatavalid, err=1 and stays 1 until rst.
REQ-040 rst asserted with 3 reads pending and buffer full -> next cycle all outputs at reset values; subsequent stale response sets err.
